// File: rtl/pif_6502_mem_bridge.sv
// Address decode and stall control between the PIF 6502 core, its registered boot ROM and sync work RAM.
// Every output is registered; the output process computes next values that the state register loads.
module pif_6502_mem_bridge #(
    parameter logic [15:0] ROM_BASE    = 16'hF000,
    parameter int          ROM_AW      = 12,
    parameter logic [15:0] RAM_BASE    = 16'h0000,
    parameter int          RAM_AW      = 11,
    parameter int          ROM_TIMEOUT = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic [15:0]       cpu_addr,
    input  logic              cpu_we,
    input  logic [7:0]        cpu_dout,
    output logic [7:0]        cpu_din,
    output logic              cpu_rdy,
    output logic [ROM_AW-1:0] rom_address,
    output logic              rom_oe,
    input  logic              rom_valid,
    input  logic [7:0]        rom_q,
    output logic [RAM_AW-1:0] ram_address,
    output logic              ram_we,
    output logic [7:0]        ram_d,
    input  logic [7:0]        ram_q,
    output logic              bus_err,
    output logic              rom_wr_err
);

    localparam int CW = $clog2(ROM_TIMEOUT + 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(ROM_TIMEOUT - 1);
    localparam logic [CW-1:0] RAM_LAST = CW'(1);

    typedef enum logic [1:0] {IDLE, ROM_WAIT, RAM_WAIT} state_t;

    state_t            state, state_nxt;
    logic [CW-1:0]     cnt, cnt_nxt;
    logic [7:0]        cpu_din_nxt, ram_d_nxt;
    logic              cpu_rdy_nxt, rom_oe_nxt, ram_we_nxt, bus_err_nxt, rom_wr_err_nxt;
    logic [ROM_AW-1:0] rom_address_nxt;
    logic [RAM_AW-1:0] ram_address_nxt;
    logic              accept, rom_hit, ram_hit;

    // Only IDLE holds cpu_rdy high, so requests during a stall are never seen.
    assign accept  = cpu_req && (state == IDLE);
    assign rom_hit = (cpu_addr[15:ROM_AW] == ROM_BASE[15:ROM_AW]);
    assign ram_hit = (cpu_addr[15:RAM_AW] == RAM_BASE[15:RAM_AW]);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            cpu_din     <= 8'h00;
            cpu_rdy     <= 1'b1;
            rom_address <= '0;
            rom_oe      <= 1'b0;
            ram_address <= '0;
            ram_we      <= 1'b0;
            ram_d       <= 8'h00;
            bus_err     <= 1'b0;
            rom_wr_err  <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            cpu_din     <= cpu_din_nxt;
            cpu_rdy     <= cpu_rdy_nxt;
            rom_address <= rom_address_nxt;
            rom_oe      <= rom_oe_nxt;
            ram_address <= ram_address_nxt;
            ram_we      <= ram_we_nxt;
            ram_d       <= ram_d_nxt;
            bus_err     <= bus_err_nxt;
            rom_wr_err  <= rom_wr_err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept && !cpu_we) begin
                    if (rom_hit)      state_nxt = ROM_WAIT;
                    else if (ram_hit) state_nxt = RAM_WAIT;
                end
            end
            ROM_WAIT: if (rom_valid || cnt == TMO_LAST) state_nxt = IDLE;
            RAM_WAIT: if (cnt == RAM_LAST) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cnt_nxt         = cnt;
        cpu_din_nxt     = cpu_din;
        cpu_rdy_nxt     = cpu_rdy;
        rom_address_nxt = rom_address;
        rom_oe_nxt      = 1'b0;
        ram_address_nxt = ram_address;
        ram_we_nxt      = 1'b0;
        ram_d_nxt       = ram_d;
        bus_err_nxt     = bus_err;
        rom_wr_err_nxt  = rom_wr_err;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (accept) begin
                    if (rom_hit) begin
                        if (cpu_we) begin
                            rom_wr_err_nxt = 1'b1;
                        end else begin
                            rom_address_nxt = cpu_addr[ROM_AW-1:0];
                            rom_oe_nxt      = 1'b1;
                            cpu_rdy_nxt     = 1'b0;
                        end
                    end else if (ram_hit) begin
                        ram_address_nxt = cpu_addr[RAM_AW-1:0];
                        if (cpu_we) begin
                            ram_d_nxt  = cpu_dout;
                            ram_we_nxt = 1'b1;
                        end else begin
                            cpu_rdy_nxt = 1'b0;
                        end
                    end else if (!cpu_we) begin
                        cpu_din_nxt = 8'hFF;
                    end
                end
            end
            ROM_WAIT: begin
                if (rom_valid) begin
                    cpu_din_nxt = rom_q;
                    cpu_rdy_nxt = 1'b1;
                end else if (cnt == TMO_LAST) begin
                    cpu_din_nxt = 8'hFF;
                    bus_err_nxt = 1'b1;
                    cpu_rdy_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            RAM_WAIT: begin
                // First edge lets the RAM register ram_q; second edge captures it.
                if (cnt == RAM_LAST) begin
                    cpu_din_nxt = ram_q;
                    cpu_rdy_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_pif_6502_mem_bridge.sv
// Directed bench for pif_6502_mem_bridge with simple registered ROM and RAM models.
module tb_pif_6502_mem_bridge;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_req = 1'b0;
    logic [15:0] cpu_addr = '0;
    logic        cpu_we = 1'b0;
    logic [7:0]  cpu_dout = '0;
    logic [7:0]  cpu_din;
    logic        cpu_rdy;
    logic [11:0] rom_address;
    logic        rom_oe;
    logic        rom_valid = 1'b0;
    logic [7:0]  rom_q = '0;
    logic [10:0] ram_address;
    logic        ram_we;
    logic [7:0]  ram_d;
    logic [7:0]  ram_q = '0;
    logic        bus_err;
    logic        rom_wr_err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int oe_cnt = 0;
    int oe_last = 0;
    int oe_prev = 0;
    int n;
    int oe_snap;
    logic rom_ena = 1'b1;
    logic inject  = 1'b0;
    logic [7:0] rom_mem [0:4095];
    logic [7:0] ram_mem [0:2047];

    pif_6502_mem_bridge dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_dout(cpu_dout),
        .cpu_din(cpu_din), .cpu_rdy(cpu_rdy),
        .rom_address(rom_address), .rom_oe(rom_oe), .rom_valid(rom_valid), .rom_q(rom_q),
        .ram_address(ram_address), .ram_we(ram_we), .ram_d(ram_d), .ram_q(ram_q),
        .bus_err(bus_err), .rom_wr_err(rom_wr_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        rom_valid <= (rom_oe && rom_ena) || inject;
        rom_q     <= rom_mem[rom_address];
        if (ram_we) ram_mem[ram_address] <= ram_d;
        ram_q     <= ram_mem[ram_address];
        cyc       <= cyc + 1;
        if (rom_oe) begin
            oe_cnt  <= oe_cnt + 1;
            oe_prev <= oe_last;
            oe_last <= cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one edge; returns just past E0.
    task automatic req(input logic [15:0] a, input logic we, input logic [7:0] d);
        cpu_req = 1'b1; cpu_addr = a; cpu_we = we; cpu_dout = d;
        tick();
        cpu_req = 1'b0;
    endtask

    task automatic wait_rdy(output int cnt);
        cnt = 0;
        while (!cpu_rdy && cnt < 20) begin
            tick();
            cnt++;
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) rom_mem[i] = 8'h00;
        for (int i = 0; i < 2048; i++) ram_mem[i] = 8'h00;
        rom_mem[12'hFFC] = 8'hA5;
        rom_mem[12'hFFD] = 8'h5A;
        rom_mem[12'h000] = 8'h11;

        // 1: reset state, then nominal ROM read
        tick(); tick();
        chk("rst_rdy", cpu_rdy, 1);
        chk("rst_din", cpu_din, 8'h00);
        chk("rst_oe", rom_oe, 0);
        chk("rst_err", {bus_err, rom_wr_err}, 0);
        reset = 1'b0;
        tick();
        req(16'hFFFC, 0, 0);
        chk("rom_oe_e0", rom_oe, 1);
        chk("rom_addr", rom_address, 12'hFFC);
        chk("rom_rdy_e0", cpu_rdy, 0);
        tick();
        chk("rom_oe_e1", rom_oe, 0);
        chk("rom_rdy_e1", cpu_rdy, 0);
        tick();
        chk("rom_rdy_e2", cpu_rdy, 1);
        chk("rom_din", cpu_din, 8'hA5);
        chk("rom_oe_cnt", oe_cnt, 1);

        // 2: RAM write then read back-to-back
        req(16'h0123, 1, 8'h3C);
        chk("ram_we_e0", ram_we, 1);
        chk("ram_addr_w", ram_address, 11'h123);
        chk("ram_d", ram_d, 8'h3C);
        chk("ram_w_rdy", cpu_rdy, 1);
        req(16'h0123, 0, 0);
        chk("ram_we_e1", ram_we, 0);
        chk("ram_r_rdy", cpu_rdy, 0);
        wait_rdy(n);
        chk("ram_stall", n, 2);
        chk("ram_din", cpu_din, 8'h3C);

        // 3: ROM timeout, late valid ignored
        rom_ena = 1'b0;
        req(16'hF000, 0, 0);
        chk("tmo_addr", rom_address, 12'h000);
        wait_rdy(n);
        chk("tmo_stall", n, 8);
        chk("tmo_din", cpu_din, 8'hFF);
        chk("tmo_berr", bus_err, 1);
        inject = 1'b1;
        tick();
        inject = 1'b0;
        tick(); tick();
        chk("late_din", cpu_din, 8'hFF);
        chk("late_rdy", cpu_rdy, 1);
        rom_ena = 1'b1;

        // 4: ROM write flagged, unmapped read returns FF without stall
        oe_snap = oe_cnt;
        req(16'hF800, 1, 8'h55);
        chk("romw_oe", rom_oe, 0);
        chk("romw_rdy", cpu_rdy, 1);
        chk("romw_err", rom_wr_err, 1);
        tick();
        chk("romw_oe_cnt", oe_cnt, oe_snap);
        req(16'h0123, 0, 0);
        wait_rdy(n);
        chk("ram_din2", cpu_din, 8'h3C);
        req(16'h4000, 0, 0);
        chk("unm_din", cpu_din, 8'hFF);
        chk("unm_rdy", cpu_rdy, 1);
        chk("sticky", {bus_err, rom_wr_err}, 2'b11);

        // 5: reset during ROM_WAIT
        req(16'hFFFC, 0, 0);
        chk("r5_rdy_e0", cpu_rdy, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("r5_rdy", cpu_rdy, 1);
        chk("r5_din", cpu_din, 8'h00);
        chk("r5_roma", rom_address, 12'h000);
        chk("r5_rama", ram_address, 11'h000);
        chk("r5_misc", {rom_oe, ram_we, ram_d, bus_err, rom_wr_err}, 0);
        oe_snap = oe_cnt;
        tick(); tick();
        chk("r5_din_hold", cpu_din, 8'h00);
        chk("r5_no_oe", oe_cnt, oe_snap);
        req(16'hFFFD, 0, 0);
        wait_rdy(n);
        chk("r5_stall", n, 2);
        chk("r5_rd", cpu_din, 8'h5A);

        // 6: back-to-back ROM reads on rdy return
        req(16'hFFFC, 0, 0);
        wait_rdy(n);
        chk("b2b_din1", cpu_din, 8'hA5);
        req(16'hFFFD, 0, 0);
        chk("b2b_acc", cpu_rdy, 0);
        wait_rdy(n);
        chk("b2b_stall", n, 2);
        chk("b2b_din2", cpu_din, 8'h5A);
        chk("b2b_gap", oe_last - oe_prev, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
